// File: rtl/axi4_mem_slave.sv
// AXI4 INCR-burst responder backed by a word array; read data 1 cycle after AR, B after last W, one burst per direction.
// Holds B/R valid+payload under backpressure. Define RESP_DELAY_EN to add DELAY wait cycles before first R beat and before B.
module axi4_mem_slave #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 12,
    parameter int DELAY      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   awid_s_inf,
    input  logic [ADDR_WIDTH-1:0] awaddr_s_inf,
    input  logic [3:0]            awlen_s_inf,
    input  logic [2:0]            awsize_s_inf,
    input  logic [1:0]            awburst_s_inf,
    input  logic                  awvalid_s_inf,
    output logic                  awready_s_inf,
    input  logic [DATA_WIDTH-1:0] wdata_s_inf,
    input  logic                  wlast_s_inf,
    input  logic                  wvalid_s_inf,
    output logic                  wready_s_inf,
    output logic [ID_WIDTH-1:0]   bid_s_inf,
    output logic [1:0]            bresp_s_inf,
    output logic                  bvalid_s_inf,
    input  logic                  bready_s_inf,
    input  logic [ID_WIDTH-1:0]   arid_s_inf,
    input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
    input  logic [3:0]            arlen_s_inf,
    input  logic [2:0]            arsize_s_inf,
    input  logic [1:0]            arburst_s_inf,
    input  logic                  arvalid_s_inf,
    output logic                  arready_s_inf,
    output logic [ID_WIDTH-1:0]   rid_s_inf,
    output logic [DATA_WIDTH-1:0] rdata_s_inf,
    output logic [1:0]            rresp_s_inf,
    output logic                  rlast_s_inf,
    output logic                  rvalid_s_inf,
    input  logic                  rready_s_inf
);

    localparam int DEPTH = 1 << MEM_AW;

`ifdef RESP_DELAY_EN
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
    localparam int DLY_W = (DELAY > 1) ? $clog2(DELAY) : 1;
    logic [DLY_W-1:0] w_dly_q, w_dly_d, r_dly_q, r_dly_d;
`else
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_DATA} r_state_e;
    localparam int unused_delay = DELAY;
`endif

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Keeps ready low until the first edge after reset release.
    logic ready_en_q;

    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [MEM_AW-1:0]     w_idx_q, w_idx_d;
    logic [3:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic                  w_err_q, w_err_d;
    logic                  wr_en;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [MEM_AW-1:0]     r_idx_q, r_idx_d;
    logic [3:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic                  r_err_q, r_err_d;
    logic                  rd_fetch;
    logic [MEM_AW-1:0]     rd_fetch_idx;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic unused_ok;
    assign unused_ok = ^{awaddr_s_inf[ADDR_WIDTH-1:MEM_AW+2], awaddr_s_inf[1:0],
                         araddr_s_inf[ADDR_WIDTH-1:MEM_AW+2], araddr_s_inf[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            w_state_q  <= W_IDLE;
            w_id_q     <= '0;
            w_idx_q    <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
            r_state_q  <= R_IDLE;
            r_id_q     <= '0;
            r_idx_q    <= '0;
            r_len_q    <= '0;
            r_cnt_q    <= '0;
            r_err_q    <= 1'b0;
            rdata_q    <= '0;
`ifdef RESP_DELAY_EN
            w_dly_q    <= '0;
            r_dly_q    <= '0;
`endif
        end else begin
            ready_en_q <= 1'b1;
            w_state_q  <= w_state_d;
            w_id_q     <= w_id_d;
            w_idx_q    <= w_idx_d;
            w_len_q    <= w_len_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
            r_state_q  <= r_state_d;
            r_id_q     <= r_id_d;
            r_idx_q    <= r_idx_d;
            r_len_q    <= r_len_d;
            r_cnt_q    <= r_cnt_d;
            r_err_q    <= r_err_d;
`ifdef RESP_DELAY_EN
            w_dly_q    <= w_dly_d;
            r_dly_q    <= r_dly_d;
`endif
            // Synchronous read: a same-cycle write to this word is not yet visible.
            if (rd_fetch) begin
                rdata_q <= mem_q[rd_fetch_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[w_idx_q] <= wdata_s_inf;
        end
    end

    always_comb begin
        w_state_d     = w_state_q;
        w_id_d        = w_id_q;
        w_idx_d       = w_idx_q;
        w_len_d       = w_len_q;
        w_cnt_d       = w_cnt_q;
        w_err_d       = w_err_q;
        wr_en         = 1'b0;
        awready_s_inf = 1'b0;
        wready_s_inf  = 1'b0;
        bvalid_s_inf  = 1'b0;
        bresp_s_inf   = 2'b00;
        bid_s_inf     = w_id_q;
`ifdef RESP_DELAY_EN
        w_dly_d       = w_dly_q;
`endif
        case (w_state_q)
            W_IDLE: begin
                awready_s_inf = ready_en_q;
                if (awvalid_s_inf && ready_en_q) begin
                    w_id_d    = awid_s_inf;
                    w_idx_d   = awaddr_s_inf[MEM_AW+1:2];
                    w_len_d   = awlen_s_inf;
                    w_cnt_d   = '0;
                    w_err_d   = (awsize_s_inf != 3'b010) || (awburst_s_inf != 2'b01);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready_s_inf = 1'b1;
                if (wvalid_s_inf) begin
                    wr_en   = 1'b1;
                    w_idx_d = w_idx_q + 1'b1;
                    w_cnt_d = w_cnt_q + 4'd1;
                    if (wlast_s_inf != (w_cnt_q == w_len_q)) begin
                        w_err_d = 1'b1;
                    end
                    if (w_cnt_q == w_len_q) begin
`ifdef RESP_DELAY_EN
                        w_dly_d   = DLY_W'(DELAY - 1);
                        w_state_d = W_WAIT;
`else
                        w_state_d = W_RESP;
`endif
                    end
                end
            end
`ifdef RESP_DELAY_EN
            W_WAIT: begin
                if (w_dly_q == '0) begin
                    w_state_d = W_RESP;
                end else begin
                    w_dly_d = w_dly_q - 1'b1;
                end
            end
`endif
            W_RESP: begin
                bvalid_s_inf = 1'b1;
                bresp_s_inf  = w_err_q ? 2'b10 : 2'b00;
                if (bready_s_inf) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d     = r_state_q;
        r_id_d        = r_id_q;
        r_idx_d       = r_idx_q;
        r_len_d       = r_len_q;
        r_cnt_d       = r_cnt_q;
        r_err_d       = r_err_q;
        rd_fetch      = 1'b0;
        rd_fetch_idx  = r_idx_q;
        arready_s_inf = 1'b0;
        rvalid_s_inf  = 1'b0;
        rlast_s_inf   = 1'b0;
        rresp_s_inf   = 2'b00;
        rid_s_inf     = r_id_q;
        rdata_s_inf   = rdata_q;
`ifdef RESP_DELAY_EN
        r_dly_d       = r_dly_q;
`endif
        case (r_state_q)
            R_IDLE: begin
                arready_s_inf = ready_en_q;
                if (arvalid_s_inf && ready_en_q) begin
                    r_id_d  = arid_s_inf;
                    r_idx_d = araddr_s_inf[MEM_AW+1:2];
                    r_len_d = arlen_s_inf;
                    r_cnt_d = '0;
                    r_err_d = (arsize_s_inf != 3'b010) || (arburst_s_inf != 2'b01);
`ifdef RESP_DELAY_EN
                    r_dly_d   = DLY_W'(DELAY - 1);
                    r_state_d = R_WAIT;
`else
                    rd_fetch     = 1'b1;
                    rd_fetch_idx = araddr_s_inf[MEM_AW+1:2];
                    r_state_d    = R_DATA;
`endif
                end
            end
`ifdef RESP_DELAY_EN
            R_WAIT: begin
                if (r_dly_q == '0) begin
                    rd_fetch  = 1'b1;
                    r_state_d = R_DATA;
                end else begin
                    r_dly_d = r_dly_q - 1'b1;
                end
            end
`endif
            R_DATA: begin
                rvalid_s_inf = 1'b1;
                rlast_s_inf  = (r_cnt_q == r_len_q);
                rresp_s_inf  = r_err_q ? 2'b10 : 2'b00;
                if (rready_s_inf) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d      = r_idx_q + 1'b1;
                        r_cnt_d      = r_cnt_q + 4'd1;
                        rd_fetch     = 1'b1;
                        rd_fetch_idx = r_idx_q + 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave (default build): burst write/read, backpressure, errors, wrap, RAW ordering, reset.
module tb_axi4_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi4_mem_slave dut (
        .clk(clk), .rst(rst),
        .awid_s_inf(awid), .awaddr_s_inf(awaddr), .awlen_s_inf(awlen), .awsize_s_inf(awsize),
        .awburst_s_inf(awburst), .awvalid_s_inf(awvalid), .awready_s_inf(awready),
        .wdata_s_inf(wdata), .wlast_s_inf(wlast), .wvalid_s_inf(wvalid), .wready_s_inf(wready),
        .bid_s_inf(bid), .bresp_s_inf(bresp), .bvalid_s_inf(bvalid), .bready_s_inf(bready),
        .arid_s_inf(arid), .araddr_s_inf(araddr), .arlen_s_inf(arlen), .arsize_s_inf(arsize),
        .arburst_s_inf(arburst), .arvalid_s_inf(arvalid), .arready_s_inf(arready),
        .rid_s_inf(rid), .rdata_s_inf(rdata), .rresp_s_inf(rresp), .rlast_s_inf(rlast),
        .rvalid_s_inf(rvalid), .rready_s_inf(rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
        awid = id; awaddr = addr; awlen = len; awsize = 3'b010; awburst = burst; awvalid = 1'b1;
        for (int n = 0; n < 50 && !awready; n++) cyc();
        chk("aw_ready", awready, 1'b1);
        cyc();
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic last);
        wdata = d; wlast = last; wvalid = 1'b1;
        for (int n = 0; n < 50 && !wready; n++) cyc();
        chk("w_ready", wready, 1'b1);
        cyc();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_b(input logic [3:0] id, input logic [1:0] resp);
        bready = 1'b1;
        for (int n = 0; n < 50 && !bvalid; n++) cyc();
        chk("b_valid", bvalid, 1'b1);
        chk("b_id", bid, id);
        chk("b_resp", bresp, resp);
        cyc();
        bready = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arsize = 3'b010; arburst = burst; arvalid = 1'b1;
        for (int n = 0; n < 50 && !arready; n++) cyc();
        chk("ar_ready", arready, 1'b1);
        cyc();
        arvalid = 1'b0;
    endtask

    task automatic rd_beat(input logic [31:0] d, input logic last, input logic [1:0] resp);
        rready = 1'b1;
        for (int n = 0; n < 50 && !rvalid; n++) cyc();
        chk("r_valid", rvalid, 1'b1);
        chk("r_data", rdata, d);
        chk("r_last", rlast, last);
        chk("r_resp", rresp, resp);
        cyc();
        rready = 1'b0;
    endtask

    initial begin
        int beat;
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        // Reset values
        cyc(); cyc();
        chk("rst_ctrl", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
        chk("rst_resp", {bresp, rresp}, 4'b0);
        chk("rst_payload", {rdata, bid, rid}, 40'b0);
        rst = 1'b0;
        cyc();
        chk("rst_release_rdy", {awready, arready, wready}, 3'b110);

        // 16-beat preload and back-to-back readback
        do_aw(4'h5, 32'h1000, 4'd15, 2'b01);
        for (int i = 0; i < 16; i++) do_w(32'(i), i == 15);
        do_b(4'h5, 2'b00);
        do_ar(4'h9, 32'h1000, 4'd15, 2'b01);
        rready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_valid", rvalid, 1'b1);
            chk("b2b_data", rdata, 32'(i));
            chk("b2b_last", rlast, i == 15);
            chk("b2b_id", rid, 4'h9);
            cyc();
        end
        rready = 1'b0;
        chk("b2b_done", {rvalid, arready}, 2'b01);

        // Backpressure: rready pattern 1,0,0,1 repeating
        do_ar(4'h3, 32'h1000, 4'd3, 2'b01);
        beat = 0;
        for (int k = 0; k < 40 && beat < 4; k++) begin
            rready = (k % 4 == 0) || (k % 4 == 3);
            chk("bp_valid", rvalid, 1'b1);
            chk("bp_data", rdata, 32'(beat));
            chk("bp_last", rlast, beat == 3);
            cyc();
            if (rready) beat++;
        end
        rready = 1'b0;
        chk("bp_beats", 32'(beat), 32'd4);
        chk("bp_idle", rvalid, 1'b0);

        // Error bursts
        do_ar(4'h2, 32'h1000, 4'd1, 2'b10);
        rd_beat(32'd0, 1'b0, 2'b10);
        rd_beat(32'd1, 1'b1, 2'b10);
        do_aw(4'h6, 32'h2000, 4'd2, 2'b01);
        do_w(32'hE0, 1'b0);
        do_w(32'hE1, 1'b1);
        do_w(32'hE2, 1'b0);
        do_b(4'h6, 2'b10);
        do_ar(4'h6, 32'h2000, 4'd2, 2'b01);
        rd_beat(32'hE0, 1'b0, 2'b00);
        rd_beat(32'hE1, 1'b0, 2'b00);
        rd_beat(32'hE2, 1'b1, 2'b00);

        // Wrap across top of memory; upper and low address bits ignored
        do_aw(4'h1, 32'h3FFC, 4'd1, 2'b01);
        do_w(32'hA, 1'b0);
        do_w(32'hB, 1'b1);
        do_b(4'h1, 2'b00);
        do_ar(4'h1, 32'h3FFC, 4'd0, 2'b01);
        rd_beat(32'hA, 1'b1, 2'b00);
        do_ar(4'h1, 32'h0000, 4'd0, 2'b01);
        rd_beat(32'hB, 1'b1, 2'b00);
        do_ar(4'h1, 32'hFFFF4000, 4'd0, 2'b01);
        rd_beat(32'hB, 1'b1, 2'b00);
        do_ar(4'h1, 32'h3FFF, 4'd1, 2'b01);
        rd_beat(32'hA, 1'b0, 2'b00);
        rd_beat(32'hB, 1'b1, 2'b00);

        // Same-cycle write and read of one word: read returns old data
        do_aw(4'h7, 32'h20, 4'd0, 2'b01);
        do_w(32'h11, 1'b1);
        do_b(4'h7, 2'b00);
        do_aw(4'h7, 32'h20, 4'd0, 2'b01);
        wdata = 32'h55; wlast = 1'b1; wvalid = 1'b1;
        arid = 4'h4; araddr = 32'h20; arlen = 4'd0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b1;
        chk("cc_same_cycle", {wready, arready}, 2'b11);
        cyc();
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        rd_beat(32'h11, 1'b1, 2'b00);
        do_b(4'h7, 2'b00);
        do_ar(4'h4, 32'h20, 4'd0, 2'b01);
        rd_beat(32'h55, 1'b1, 2'b00);

        // Reset during beat 2 of an 8-beat read
        do_ar(4'h8, 32'h1000, 4'd7, 2'b01);
        rready = 1'b1;
        cyc(); cyc();
        chk("mid_beat2", rdata, 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {rvalid, rlast, arready, awready, wready, bvalid}, 6'b0);
        rready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_arready", arready, 1'b1);
        do_ar(4'h8, 32'h1000, 4'd1, 2'b01);
        rd_beat(32'd0, 1'b0, 2'b00);
        rd_beat(32'd1, 1'b1, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
